lcd_hd44780_seq: RTL and testbench



---
 rtl/lcd_hd44780_seq.sv | 157 +++++++++++++++
 tb/tb_lcd_hd44780_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_seq.sv
// lcd_hd44780_seq: power-up init and two-line refresh sequencer for an HD44780 2x16 LCD
module lcd_hd44780_seq #(
  parameter int T_PWRUP_CYC = 1500000,
  parameter int T_AS_CYC    = 4,
  parameter int T_EN_CYC    = 50,
  parameter int T_CMD_CYC   = 4000,
  parameter int T_CLR_CYC   = 160000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        lcd_valid,
  output logic        lcd_ready,
  input  logic [31:0] lcd_data_str_0_0,
  input  logic [31:0] lcd_data_str_0_1,
  input  logic [31:0] lcd_data_str_0_2,
  input  logic [31:0] lcd_data_str_0_3,
  input  logic [31:0] lcd_data_str_1_0,
  input  logic [31:0] lcd_data_str_1_1,
  input  logic [31:0] lcd_data_str_1_2,
  input  logic [31:0] lcd_data_str_1_3,
  output logic        LCD_E,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic [7:0]  LCD_DB
);
  localparam int M0 = T_PWRUP_CYC > T_AS_CYC ? T_PWRUP_CYC : T_AS_CYC;
  localparam int M1 = M0 > T_EN_CYC ? M0 : T_EN_CYC;
  localparam int M2 = M1 > T_CMD_CYC ? M1 : T_CMD_CYC;
  localparam int T_MAX = M2 > T_CLR_CYC ? M2 : T_CLR_CYC;
  localparam int W = $clog2(T_MAX + 1);
  localparam logic [W-1:0] C_PWR = W'(T_PWRUP_CYC - 1);
  localparam logic [W-1:0] C_AS  = W'(T_AS_CYC - 1);
  localparam logic [W-1:0] C_EN  = W'(T_EN_CYC - 1);
  localparam logic [W-1:0] C_CMD = W'(T_CMD_CYC - 1);
  localparam logic [W-1:0] C_CLR = W'(T_CLR_CYC - 1);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR0, LINE0, ADDR1, LINE1} state_t;
  typedef enum logic [1:0] {SETUP, EN_HI, HOLD, WAIT} phase_t;

  state_t state, state_n, tgt;
  phase_t phase, phase_n;
  logic [W-1:0] cnt, cnt_n, lim;
  logic [3:0] idx, idx_n, tidx, last;
  logic clr, clr_n, pending, pend_n, e_n, rs_n, go, shd_in, take_in, take_shd;
  logic [7:0] db_n;
  logic [255:0] active, shadow, din;

  // Line L char i lives at din[128*L + 8*i +: 8]
  assign din = {lcd_data_str_1_3, lcd_data_str_1_2, lcd_data_str_1_1, lcd_data_str_1_0,
                lcd_data_str_0_3, lcd_data_str_0_2, lcd_data_str_0_1, lcd_data_str_0_0};
  assign lcd_ready = state == IDLE && !pending;
  assign LCD_RW = 1'b0;
  assign last = state == INIT ? 4'd5 : (state == LINE0 || state == LINE1) ? 4'd15 : 4'd0;
  assign lim = phase == EN_HI ? C_EN : phase == WAIT ? (clr ? C_CLR : C_CMD) : C_AS;

  always_comb begin
    state_n = state;
    phase_n = phase;
    idx_n = idx;
    cnt_n = cnt + 1'b1;
    e_n = LCD_E;
    rs_n = LCD_RS;
    db_n = LCD_DB;
    clr_n = clr;
    go = 1'b0;
    tgt = state;
    tidx = 4'd0;
    shd_in = lcd_valid && state != IDLE;
    take_in = 1'b0;
    take_shd = 1'b0;
    pend_n = pending || shd_in;
    if (state == PWRUP) begin
      if (cnt == C_PWR) begin
        go = 1'b1;
        tgt = INIT;
      end
    end else if (state == IDLE) begin
      cnt_n = '0;
      if (lcd_valid || pending) begin
        go = 1'b1;
        tgt = ADDR0;
        take_in = lcd_valid;
        take_shd = !lcd_valid;
        pend_n = 1'b0;
      end
    end else if (cnt == lim) begin
      cnt_n = '0;
      if (phase == SETUP) begin
        phase_n = EN_HI;
        e_n = 1'b1;
      end else if (phase == EN_HI) begin
        phase_n = HOLD;
        e_n = 1'b0;
      end else if (phase == HOLD) begin
        phase_n = WAIT;
      end else if (idx != last) begin
        go = 1'b1;
        tidx = idx + 4'd1;
      end else if (state == INIT || state == LINE1) begin
        // A pulse arriving while pending is consumed refills the shadow
        if (pending) begin
          go = 1'b1;
          tgt = ADDR0;
          take_shd = 1'b1;
          pend_n = shd_in;
        end else begin
          state_n = IDLE;
        end
      end else begin
        go = 1'b1;
        tgt = state == ADDR0 ? LINE0 : state == LINE0 ? ADDR1 : LINE1;
      end
    end
    if (go) begin
      state_n = tgt;
      phase_n = SETUP;
      idx_n = tidx;
      cnt_n = '0;
      e_n = 1'b0;
      rs_n = tgt == LINE0 || tgt == LINE1;
      clr_n = tgt == INIT && (tidx < 4'd3 || tidx == 4'd4);
      db_n = tgt == ADDR0 ? 8'h80 : tgt == ADDR1 ? 8'hC0 :
             tgt != INIT ? active[{tgt == LINE1, tidx, 3'b000} +: 8] :
             tidx == 4'd3 ? 8'h0C : tidx == 4'd4 ? 8'h01 : tidx == 4'd5 ? 8'h06 : 8'h38;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state <= PWRUP;
      phase <= SETUP;
      cnt <= '0;
      idx <= '0;
      clr <= 1'b0;
      pending <= 1'b0;
      LCD_E <= 1'b0;
      LCD_RS <= 1'b0;
      LCD_DB <= 8'h00;
    end else begin
      state <= state_n;
      phase <= phase_n;
      cnt <= cnt_n;
      idx <= idx_n;
      clr <= clr_n;
      pending <= pend_n;
      LCD_E <= e_n;
      LCD_RS <= rs_n;
      LCD_DB <= db_n;
    end
  end

  always_ff @(posedge ACLK) begin
    if (take_in) active <= din;
    else if (take_shd) active <= shadow;
    if (shd_in) shadow <= din;
  end
endmodule

// File: tb/tb_lcd_hd44780_seq.sv
// tb_lcd_hd44780_seq: scoreboard bench for the HD44780 sequencer with shortened timings
module tb_lcd_hd44780_seq;
  timeunit 1ns;
  timeprecision 1ps;
  localparam int T_PWRUP = 20, T_AS = 2, T_EN = 3, T_CMD = 5, T_CLR = 10;
  localparam int XFER_CMD = 2 * T_AS + T_EN + T_CMD;
  localparam int XFER_CLR = 2 * T_AS + T_EN + T_CLR;
  localparam int INIT_CYC = T_PWRUP + 4 * XFER_CLR + 2 * XFER_CMD;
  localparam int REFRESH_CYC = 34 * XFER_CMD;

  logic clk = 1'b0, ARESET = 1'b1, lcd_valid = 1'b0;
  logic lcd_ready, LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DB;
  logic [31:0] str [2][4];
  logic [8:0] q[$];
  logic [8:0] exp_x, bus_prev = 9'h0, bus_cap = 9'h0;
  logic e_prev = 1'b0;
  int hi = 0, stable = 0, cmp = 0, err = 0;

  lcd_hd44780_seq #(.T_PWRUP_CYC(T_PWRUP), .T_AS_CYC(T_AS), .T_EN_CYC(T_EN),
                    .T_CMD_CYC(T_CMD), .T_CLR_CYC(T_CLR)) dut (
    .ACLK(clk), .ARESET(ARESET), .lcd_valid(lcd_valid), .lcd_ready(lcd_ready),
    .lcd_data_str_0_0(str[0][0]), .lcd_data_str_0_1(str[0][1]),
    .lcd_data_str_0_2(str[0][2]), .lcd_data_str_0_3(str[0][3]),
    .lcd_data_str_1_0(str[1][0]), .lcd_data_str_1_1(str[1][1]),
    .lcd_data_str_1_2(str[1][2]), .lcd_data_str_1_3(str[1][3]),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DB(LCD_DB));

  always #5 clk = ~clk;

  // Each E rising edge consumes one expected {RS,DB}; width, setup and hold are checked too
  always @(negedge clk) begin
    if (ARESET) begin
      e_prev = 1'b0;
      hi = 0;
      stable = 0;
      bus_prev = 9'h0;
    end else begin
      stable = ({LCD_RS, LCD_DB} == bus_prev) ? stable + 1 : 0;
      bus_prev = {LCD_RS, LCD_DB};
      if (LCD_E && !e_prev) begin
        hi = 1;
        bus_cap = bus_prev;
        cmp++;
        if (q.size() == 0) begin
          err++;
          $display("FAIL pulse: got unexpected rs=%0b db=%02h, required no pulse", LCD_RS, LCD_DB);
        end else begin
          exp_x = q.pop_front();
          if (bus_prev !== exp_x) begin
            err++;
            $display("FAIL pulse: got rs=%0b db=%02h, required rs=%0b db=%02h",
                     LCD_RS, LCD_DB, exp_x[8], exp_x[7:0]);
          end
        end
        cmp++;
        if (stable < T_AS) begin
          err++;
          $display("FAIL setup: got %0d stable cycles, required >= %0d", stable, T_AS);
        end
        cmp++;
        if (LCD_RW !== 1'b0) begin
          err++;
          $display("FAIL rw: got %b, required 0", LCD_RW);
        end
      end else if (LCD_E) begin
        hi++;
        cmp++;
        if (bus_prev !== bus_cap) begin
          err++;
          $display("FAIL bus_while_e: got %03h, required %03h", bus_prev, bus_cap);
        end
      end else if (e_prev) begin
        cmp++;
        if (hi != T_EN) begin
          err++;
          $display("FAIL e_width: got %0d cycles, required %0d", hi, T_EN);
        end
        cmp++;
        if (bus_prev !== bus_cap) begin
          err++;
          $display("FAIL hold: got %03h, required %03h", bus_prev, bus_cap);
        end
      end
      e_prev = LCD_E;
    end
  end

  task automatic set_text(input string l0, input string l1);
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++) begin
        str[0][w][8*b +: 8] = l0[4*w+b];
        str[1][w][8*b +: 8] = l1[4*w+b];
      end
  endtask

  task automatic push_init;
    q.push_back({1'b0, 8'h38});
    q.push_back({1'b0, 8'h38});
    q.push_back({1'b0, 8'h38});
    q.push_back({1'b0, 8'h0C});
    q.push_back({1'b0, 8'h01});
    q.push_back({1'b0, 8'h06});
  endtask

  task automatic push_refresh(input string l0, input string l1);
    q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) q.push_back({1'b1, 8'(l0[i])});
    q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) q.push_back({1'b1, 8'(l1[i])});
  endtask

  task automatic pulse(input string l0, input string l1);
    set_text(l0, l1);
    lcd_valid = 1'b1;
    @(posedge clk);
    #1 lcd_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!lcd_ready && n < budget);
    if (!lcd_ready) n = -1;
  endtask

  task automatic test_reset;
    ARESET = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp++;
    if (LCD_E !== 1'b0) begin err++; $display("FAIL reset_e: got %b, required 0", LCD_E); end
    cmp++;
    if (LCD_RS !== 1'b0) begin err++; $display("FAIL reset_rs: got %b, required 0", LCD_RS); end
    cmp++;
    if (LCD_RW !== 1'b0) begin err++; $display("FAIL reset_rw: got %b, required 0", LCD_RW); end
    cmp++;
    if (LCD_DB !== 8'h00) begin err++; $display("FAIL reset_db: got %02h, required 00", LCD_DB); end
    cmp++;
    if (lcd_ready !== 1'b0) begin err++; $display("FAIL reset_ready: got %b, required 0", lcd_ready); end
  endtask

  task automatic test_init;
    int n_e = -1, n_r = -1;
    @(posedge clk);
    #1 ARESET = 1'b0;
    push_init();
    for (int n = 1; n <= 400 && n_r < 0; n++) begin
      @(posedge clk);
      #1;
      if (LCD_E && n_e < 0) n_e = n;
      if (lcd_ready) n_r = n;
    end
    cmp++;
    if (n_e != T_PWRUP + T_AS) begin err++; $display("FAIL init_first_e: got cycle %0d, required %0d", n_e, T_PWRUP + T_AS); end
    cmp++;
    if (n_r != INIT_CYC) begin err++; $display("FAIL init_ready: got cycle %0d, required %0d", n_r, INIT_CYC); end
    cmp++;
    if (q.size() != 0) begin err++; $display("FAIL init_left: got %0d pending pulses, required 0", q.size()); end
    repeat (20) @(posedge clk);
    #1 cmp++;
    if (lcd_ready !== 1'b1) begin err++; $display("FAIL init_idle: got ready=%b, required 1", lcd_ready); end
  endtask

  task automatic test_update;
    int n;
    str[0][0] = 32'h4C4C4548;
    str[0][1] = 32'h4F57204F;
    str[0][2] = 32'h21444C52;
    str[0][3] = 32'h20202020;
    for (int w = 0; w < 4; w++) str[1][w] = 32'h20202020;
    push_refresh("HELLO WORLD!    ", "                ");
    lcd_valid = 1'b1;
    @(posedge clk);
    #1 lcd_valid = 1'b0;
    cmp++;
    if (lcd_ready !== 1'b0) begin err++; $display("FAIL update_busy: got ready=%b, required 0", lcd_ready); end
    wait_ready(1000, n);
    cmp++;
    if (n != REFRESH_CYC) begin err++; $display("FAIL update_ready: got cycle %0d, required %0d", n, REFRESH_CYC); end
    cmp++;
    if (q.size() != 0) begin err++; $display("FAIL update_left: got %0d pending pulses, required 0", q.size()); end
  endtask

  task automatic test_snapshot;
    int n;
    push_refresh("SNAPSHOT TEXT 01", "abcdefghijklmnop");
    pulse("SNAPSHOT TEXT 01", "abcdefghijklmnop");
    for (int l = 0; l < 2; l++)
      for (int w = 0; w < 4; w++) str[l][w] = 32'hFFFFFFFF;
    wait_ready(1000, n);
    cmp++;
    if (n != REFRESH_CYC) begin err++; $display("FAIL snap_ready: got cycle %0d, required %0d", n, REFRESH_CYC); end
    cmp++;
    if (q.size() != 0) begin err++; $display("FAIL snap_left: got %0d pending pulses, required 0", q.size()); end
  endtask

  task automatic test_back_to_back;
    int n;
    push_refresh("Refresh number 1", "line one below..");
    push_refresh("text B top row  ", "text B bottom   ");
    pulse("Refresh number 1", "line one below..");
    repeat (50) @(posedge clk);
    #1 pulse("text A top row  ", "text A bottom   ");
    repeat (100) @(posedge clk);
    #1 pulse("text B top row  ", "text B bottom   ");
    set_text("text A top row  ", "text A bottom   ");
    wait_ready(2000, n);
    cmp++;
    if (n != 2 * REFRESH_CYC - 152) begin err++; $display("FAIL b2b_ready: got cycle %0d, required %0d", n, 2 * REFRESH_CYC - 152); end
    cmp++;
    if (q.size() != 0) begin err++; $display("FAIL b2b_left: got %0d pending pulses, required 0", q.size()); end
  endtask

  task automatic test_valid_in_init;
    int n;
    ARESET = 1'b1;
    @(posedge clk);
    #1 ARESET = 1'b0;
    push_init();
    push_refresh("init time valid!", "0123456789ABCDEF");
    repeat (39) @(posedge clk);
    #1 pulse("init time valid!", "0123456789ABCDEF");
    wait_ready(2000, n);
    cmp++;
    if (40 + n != INIT_CYC + REFRESH_CYC) begin err++; $display("FAIL init_valid_ready: got cycle %0d, required %0d", 40 + n, INIT_CYC + REFRESH_CYC); end
    cmp++;
    if (q.size() != 0) begin err++; $display("FAIL init_valid_left: got %0d pending pulses, required 0", q.size()); end
  endtask

  task automatic test_abort;
    int n;
    logic found = 1'b0;
    push_refresh("abort me please.", "dddddddddddddddd");
    pulse("abort me please.", "dddddddddddddddd");
    pulse("never shown ever", "eeeeeeeeeeeeeeee");
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = LCD_E && LCD_RS;
    end
    cmp++;
    if (!found) begin err++; $display("FAIL abort_find: got no data pulse, required one"); end
    @(posedge clk);
    #1 ARESET = 1'b1;
    q.delete();
    push_init();
    @(posedge clk);
    #1 ARESET = 1'b0;
    @(negedge clk);
    cmp++;
    if (LCD_E !== 1'b0) begin err++; $display("FAIL abort_e: got %b, required 0", LCD_E); end
    cmp++;
    if (LCD_DB !== 8'h00) begin err++; $display("FAIL abort_db: got %02h, required 00", LCD_DB); end
    cmp++;
    if (lcd_ready !== 1'b0) begin err++; $display("FAIL abort_ready: got %b, required 0", lcd_ready); end
    wait_ready(500, n);
    cmp++;
    if (n != INIT_CYC) begin err++; $display("FAIL abort_reinit: got cycle %0d, required %0d", n, INIT_CYC); end
    repeat (40) @(posedge clk);
    #1 cmp++;
    if (lcd_ready !== 1'b1) begin err++; $display("FAIL abort_idle: got ready=%b, required 1", lcd_ready); end
    cmp++;
    if (q.size() != 0) begin err++; $display("FAIL abort_left: got %0d pending pulses, required 0", q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < 2; l++)
      for (int w = 0; w < 4; w++) str[l][w] = 32'h0;
    test_reset();
    test_init();
    test_update();
    test_snapshot();
    test_back_to_back();
    test_valid_in_init();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
